// File: rtl/toy_pack.sv
// Shared widths and write-buffer entry layout for the icache data-array arbiter.
// Imported by the arbiter top and its linefill write-buffer FIFO.
package toy_pack;

  localparam int ICACHE_INDEX_WIDTH     = 8;
  localparam int ICACHE_DATA_WIDTH      = 256;
  localparam int ICACHE_REQ_TXNID_WIDTH = 8;

  typedef struct packed {
    logic [ICACHE_INDEX_WIDTH-1:0] addr;
    logic [ICACHE_DATA_WIDTH-1:0]  data;
  } wbuf_entry_t;

endpackage

// File: rtl/icache_wbuf_fifo.sv
// In-order linefill write buffer; exposes per-entry valid bits and addresses
// so the arbiter can detect read-after-pending-write hazards.
module icache_wbuf_fifo
  import toy_pack::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = ICACHE_INDEX_WIDTH,
  parameter int DW    = ICACHE_DATA_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [AW-1:0]       push_addr,
  input  logic [DW-1:0]       push_data,
  input  logic                pop,
  output logic [AW-1:0]       head_addr,
  output logic [DW-1:0]       head_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH-1:0]    entry_vld,
  output logic [DEPTH*AW-1:0] entry_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;
  logic [PW-1:0] offset;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Payload storage carries no reset; validity comes solely from count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    entry_vld  = '0;
    entry_addr = '0;
    offset     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset                = PW'(i) - rd_ptr;
      entry_vld[i]          = ({1'b0, offset} < count);
      entry_addr[i*AW +: AW] = addr_q[i];
    end
  end

endmodule

// File: rtl/icache_data_array_arb.sv
// Single-port icache data-array arbiter between fetch reads and buffered linefill
// writes; reads win unless the buffer is full, a hazard exists, or the read streak caps.
module icache_data_array_arb
  import toy_pack::*;
#(
  parameter int ADDR_W        = ICACHE_INDEX_WIDTH,
  parameter int DATA_W        = ICACHE_DATA_WIDTH,
  parameter int TXNID_W       = ICACHE_REQ_TXNID_WIDTH,
  parameter int WBUF_DEPTH    = 2,
  parameter int MAX_RD_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_vld,
  output logic               rd_rdy,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic [TXNID_W-1:0] rd_txnid,
  input  logic               wr_vld,
  output logic               wr_rdy,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               mem_en,
  output logic               mem_wr_en,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_din,
  input  logic [DATA_W-1:0]  mem_dout,
  output logic               rsp_vld,
  output logic [TXNID_W-1:0] rsp_txnid,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               wbuf_empty
);

  localparam int SW = $clog2(MAX_RD_STREAK + 1);

  logic [ADDR_W-1:0]            head_addr;
  logic [DATA_W-1:0]            head_data;
  logic                         full;
  logic                         empty;
  logic [WBUF_DEPTH-1:0]        entry_vld;
  logic [WBUF_DEPTH*ADDR_W-1:0] entry_addr;
  logic                         hazard;
  logic                         drain;
  logic                         rd_grant;
  logic [SW-1:0]                streak;

  icache_wbuf_fifo #(
    .DEPTH (WBUF_DEPTH),
    .AW    (ADDR_W),
    .DW    (DATA_W)
  ) u_wbuf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (wr_vld && wr_rdy),
    .push_addr  (wr_addr),
    .push_data  (wr_data),
    .pop        (drain),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty),
    .entry_vld  (entry_vld),
    .entry_addr (entry_addr)
  );

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (entry_vld[i] && (entry_addr[i*ADDR_W +: ADDR_W] == rd_addr)) hazard = 1'b1;
    end
  end

  // A same-cycle enqueue is not yet in the buffer, so a matching read goes first.
  assign drain    = !empty && (!rd_vld || full || (streak == SW'(MAX_RD_STREAK)) || hazard);
  assign rd_grant = rd_vld && !drain;

  assign rd_rdy     = rd_grant;
  assign wr_rdy     = !full;
  assign wbuf_empty = empty;

  assign mem_en    = drain || rd_grant;
  assign mem_wr_en = drain;
  assign mem_addr  = drain ? head_addr : rd_addr;
  assign mem_din   = head_data;
  assign rsp_data  = mem_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (drain || empty) begin
      streak <= '0;
    end else if (rd_grant && (streak != SW'(MAX_RD_STREAK))) begin
      streak <= streak + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld   <= 1'b0;
      rsp_txnid <= '0;
    end else begin
      rsp_vld <= rd_grant;
      if (rd_grant) rsp_txnid <= rd_txnid;
    end
  end

endmodule

// File: doc/icache_data_array_arb.md
ICACHE_DATA_ARRAY_ARB -- requirements
Module: icache_data_array_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, data-array address width ({index,way}).
REQ-002 SHALL have parameter DATA_W, default 256, data-array word width.
REQ-003 SHALL have parameter TXNID_W, default 8, read transaction-id width.
REQ-004 SHALL have parameter WBUF_DEPTH, default 2, linefill write-buffer entries (power of two, >=2).
REQ-005 SHALL have parameter MAX_RD_STREAK, default 4, maximum consecutive read grants while writes pend.
REQ-006 SHALL have ports:
 clk  in  1  clock; reset is rst_n, asynchronous, active-low; clock is clk.
 rst_n  in  1  asynchronous active-low reset.
 rd_vld  in  1  fetch read request.
 rd_rdy  out  1  read accepted this cycle.
 rd_addr  in  ADDR_W  read address.
 rd_txnid  in  TXNID_W  read txn id.
 wr_vld  in  1  linefill write request.
 wr_rdy  out  1  write accepted into buffer.
 wr_addr  in  ADDR_W  write address.
 wr_data  in  DATA_W  linefill data.
 mem_en  out  1  SRAM enable.
 mem_wr_en  out  1  SRAM write enable.
 mem_addr  out  ADDR_W  SRAM address.
 mem_din  out  DATA_W  SRAM write data.
 mem_dout  in  DATA_W  SRAM read data, valid one cycle after read enable.
 rsp_vld  out  1  read data valid.
 rsp_txnid  out  TXNID_W  txn id of rsp_data.
 rsp_data  out  DATA_W  read data.
 wbuf_empty  out  1  no pending writes.

Function
REQ-007 Writes SHALL enqueue into an in-order FIFO when wr_vld && wr_rdy; wr_rdy = !full (no same-cycle drain credit).
REQ-008 Each cycle exactly one of {write-drain, read, idle} SHALL be granted to the SRAM.
REQ-009 Write-drain SHALL be granted when buffer non-empty AND (!rd_vld OR full OR streak==MAX_RD_STREAK OR hazard); otherwise read granted if rd_vld.
REQ-010 hazard = rd_addr equals addr of any valid buffer entry; read SHALL stall until matching entry drained.
REQ-011 rd_rdy = rd_vld && !write-drain-grant; combinational, no dependence on rsp side.
REQ-012 Read grant: mem_en=1, mem_wr_en=0, mem_addr=rd_addr. Write-drain: mem_en=1, mem_wr_en=1, mem_addr/mem_din = FIFO head; head popped same cycle. Idle: mem_en=0.
REQ-013 rsp_vld SHALL assert exactly one cycle after each read grant; rsp_txnid registered at grant; rsp_data = mem_dout passthrough.
REQ-014 streak counter (saturating at MAX_RD_STREAK) SHALL increment on read grant while buffer non-empty, clear on write-drain grant or when buffer empty.
REQ-015 Read accepted in same cycle as an enqueue of the same address SHALL return pre-write data (read ordered before write).
REQ-016 Simultaneous enqueue and drain SHALL keep count unchanged; pointers wrap modulo WBUF_DEPTH.
REQ-017 wbuf_empty = (count==0), registered-state derived.

Reset
REQ-018 On rst_n low: FIFO count/pointers=0, streak=0, rsp_vld=0, rsp_txnid=0; thus wbuf_empty=1, wr_rdy=1, mem_en=0.
REQ-019 Reset mid-operation SHALL discard pending writes and any in-flight response; buffer data contents need no reset.

Structure
REQ-020 Width constants (ICACHE_INDEX_WIDTH, ICACHE_DATA_WIDTH, ICACHE_REQ_TXNID_WIDTH) and wbuf entry typedef {addr,data} SHALL live in toy_pack.
REQ-021 FIFO SHALL be sub-module icache_wbuf_fifo exposing entry-valid/address vector for hazard compare.

Verification
REQ-022 Idle, rd_vld addr=0x10 txnid=3 -> mem_en=1,wr_en=0 same cycle; next cycle rsp_vld=1, rsp_txnid=3.
REQ-023 Write addr=0x22 data=A then 6 back-to-back reads to 0x05 -> reads granted 4 cycles, cycle 5 write-drains (rd_rdy=0), read 6 follows.
REQ-024 Write 0x22 data=B enqueued, then read 0x22 -> rd_rdy=0 one cycle, write drains, read granted next, rsp_data=B.
REQ-025 Two writes with continuous reads -> full, wr_rdy=0; next cycle write drains, wr_rdy=1 following cycle.
REQ-026 Read 0x30 and write 0x30 data=C same cycle, empty buffer -> rsp_data old value; later read returns C.
REQ-027 Assert rst_n low with 2 writes pending and rsp in flight -> rsp_vld=0, wbuf_empty=1, no SRAM write after release.
